// File: rtl/mac_diff_pkg.sv
// Shared types and width helpers for the ROM-fed multiply/accumulate difference engine.
package mac_diff_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MUL   = 3'd2,
        ACC   = 3'd3,
        FINAL = 3'd4
    } state_t;

    // Lossless accumulator width: full product plus headroom for ITERS additions and sign.
    function automatic int acc_width(input int data_w, input int iters);
        return 2 * data_w + $clog2(iters) + 1;
    endfunction

    function automatic int res_width(input int data_w, input int iters, input int lanes);
        return acc_width(data_w, iters) + $clog2(lanes);
    endfunction

endpackage

// File: rtl/mac_lane_acc.sv
// One multiply lane: a registered product and a running accumulator, both mode-aware
// so unsigned operands never get misread as negative once widened.
module mac_lane_acc #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_p,
    input  logic              load_s,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [ACC_W-1:0]  s
);

    localparam int P_W = 2 * DATA_W;

    logic [P_W-1:0]   x_ext_s;
    logic [P_W-1:0]   y_ext_s;
    logic [P_W-1:0]   prod_s;
    logic [ACC_W-1:0] p_ext_s;
    logic [P_W-1:0]   p_r;
    logic [ACC_W-1:0] acc_r;

    // Widen operands to product width; the truncated product is then exact in either mode.
    always_comb begin
        if (signed_mode) begin
            x_ext_s = {{DATA_W{x[DATA_W-1]}}, x};
            y_ext_s = {{DATA_W{y[DATA_W-1]}}, y};
            p_ext_s = {{(ACC_W-P_W){p_r[P_W-1]}}, p_r};
        end else begin
            x_ext_s = {{DATA_W{1'b0}}, x};
            y_ext_s = {{DATA_W{1'b0}}, y};
            p_ext_s = {{(ACC_W-P_W){1'b0}}, p_r};
        end
        prod_s = x_ext_s * y_ext_s;
    end

    // Product and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r   <= '0;
            acc_r <= '0;
        end else if (clear) begin
            p_r   <= '0;
            acc_r <= '0;
        end else begin
            if (load_p) begin
                p_r <= prod_s;
            end
            if (load_s) begin
                acc_r <= acc_r + p_ext_s;
            end
        end
    end

    assign s = acc_r;

endmodule

// File: rtl/mac_diff_engine.sv
// Controller and address counter for the multiply/accumulate difference engine;
// lanes are multiplied one per cycle and accumulated together once per fetched word.
module mac_diff_engine
    import mac_diff_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int LANES     = 4,
    parameter int ITERS     = 4,
    parameter int ADDR_W    = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        signed_mode,
    input  logic [ADDR_W-1:0]                           base_addr,
    output logic [ADDR_W-1:0]                           rom_addr,
    input  logic [2*LANES*DATA_W-1:0]                   rom_data,
    output logic                                        busy,
    output logic                                        done,
    output logic [res_width(DATA_W, ITERS, LANES)-1:0]  result
);

    localparam int WORD_W  = 2 * LANES * DATA_W;
    localparam int ACC_W   = acc_width(DATA_W, ITERS);
    localparam int RES_W   = res_width(DATA_W, ITERS, LANES);
    localparam int LANE_CW = $clog2(LANES);
    localparam int ITER_CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t               state_r;
    logic                 sign_r;
    logic [LANE_CW-1:0]   lane_r;
    logic [ITER_CW-1:0]   iter_r;
    logic [WORD_W-1:0]    word_r;
    logic                 clear_s;
    logic                 load_s_s;
    logic [ACC_W-1:0]     acc_s [LANES];
    logic [RES_W-1:0]     diff_sum_s;

    assign clear_s  = (state_r == IDLE) && start;
    assign load_s_s = (state_r == ACC);

    // Alternating-sign reduction over lane pairs, all at result width.
    always_comb begin
        diff_sum_s = '0;
        for (int k = 0; k < LANES / 2; k++) begin
            diff_sum_s = diff_sum_s
                       + {{(RES_W-ACC_W){acc_s[2*k][ACC_W-1]}}, acc_s[2*k]}
                       - {{(RES_W-ACC_W){acc_s[2*k+1][ACC_W-1]}}, acc_s[2*k+1]};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane_acc #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear_s),
            .load_p      ((state_r == MUL) && (lane_r == LANE_CW'(i))),
            .load_s      (load_s_s),
            .signed_mode (sign_r),
            .x           (word_r[i*DATA_W +: DATA_W]),
            .y           (word_r[(LANES+i)*DATA_W +: DATA_W]),
            .s           (acc_s[i])
        );
    end

    // Run sequencing, address counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            sign_r   <= 1'b0;
            lane_r   <= '0;
            iter_r   <= '0;
            word_r   <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rom_addr <= base_addr;
                        sign_r   <= signed_mode;
                        iter_r   <= '0;
                        lane_r   <= '0;
                        busy     <= 1'b1;
                        state_r  <= FETCH;
                    end
                end
                FETCH: begin
                    word_r   <= rom_data;
                    rom_addr <= rom_addr + ADDR_W'(ADDR_STEP);
                    lane_r   <= '0;
                    state_r  <= MUL;
                end
                MUL: begin
                    if (lane_r == LANE_CW'(LANES - 1)) begin
                        state_r <= ACC;
                    end else begin
                        lane_r <= lane_r + LANE_CW'(1);
                    end
                end
                ACC: begin
                    if (iter_r == ITER_CW'(ITERS - 1)) begin
                        state_r <= FINAL;
                    end else begin
                        iter_r  <= iter_r + ITER_CW'(1);
                        state_r <= FETCH;
                    end
                end
                FINAL: begin
                    result  <= diff_sum_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_diff_engine.sv
// Randomized and directed bench for mac_diff_engine with a queue-based scoreboard
// and an arithmetic reference model of the engine's result.
module tb_mac_diff_engine;

    localparam int LAT = 25;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [3:0]  base_addr;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic        done;
    logic [12:0] result;

    logic [31:0] rom_mem [16];
    assign rom_data = rom_mem[rom_addr];

    typedef struct {
        logic [12:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_busy = 1'b0;

    mac_diff_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .base_addr   (base_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic over the words the run should read.
    function automatic logic [12:0] model(input logic [3:0] base, input logic sm);
        int          s [4];
        int          xv, yv, r;
        logic [31:0] w;
        logic [3:0]  a, b;
        for (int i = 0; i < 4; i++) s[i] = 0;
        for (int it = 0; it < 4; it++) begin
            w = rom_mem[(int'(base) + it * 4) % 16];
            for (int i = 0; i < 4; i++) begin
                a  = w[i*4 +: 4];
                b  = w[(4+i)*4 +: 4];
                xv = int'(a);
                yv = int'(b);
                if (sm && a[3]) xv -= 16;
                if (sm && b[3]) yv -= 16;
                s[i] += xv * yv;
            end
        end
        r = (s[0] - s[1]) + (s[2] - s[3]);
        return r[12:0];
    endfunction

    // Monitor: every done must match the oldest expectation in value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("busy_before_done", 32'(prev_busy), 32'd1);
            end
        end
        prev_busy = busy;
    end

    // Call just after a falling edge; start is accepted at the next rising edge.
    task automatic launch(input logic [3:0] base, input logic sm, input logic [12:0] exp_res,
                          output int e0);
        exp_t e;
        base_addr   = base;
        signed_mode = sm;
        start       = 1'b1;
        e0          = cyc + 1;
        e.res       = exp_res;
        e.cyc       = e0 + LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 16; i++) rom_mem[i] = w;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) rom_mem[i] = $urandom;
    endtask

    initial begin
        int          e0;
        logic [3:0]  b;
        logic        m;
        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        base_addr = 4'h0;
        fill(32'h0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fill(32'h1111_4321);
        launch(4'h0, 1'b0, 13'h1FF8, e0);
        drain();

        fill(32'h1F1F_1111);
        launch(4'h0, 1'b1, 13'h1FF0, e0);
        drain();
        launch(4'h0, 1'b0, 13'h0070, e0);
        drain();

        fill(32'hF0F0_FFFF);
        launch(4'h0, 1'b0, 13'h18F8, e0);
        drain();

        // Wrapping addresses, then a restart in the done cycle.
        fill_random();
        launch(4'hC, 1'b1, model(4'hC, 1'b1), e0);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(e0 + 6 * k);
            chk("rom_addr_seq", 32'(rom_addr), 32'((12 + 4 * k) % 16));
        end
        wait_cyc(e0 + LAT);
        chk("done_for_restart", 32'(done), 32'd1);
        launch(4'hC, 1'b1, model(4'hC, 1'b1), e0);
        drain();

        // A start mid-run must be ignored.
        fill_random();
        launch(4'h4, 1'b0, model(4'h4, 1'b0), e0);
        wait_cyc(e0 + 9);
        base_addr   = 4'h8;
        signed_mode = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of the multiply phase.
        launch(4'h0, 1'b1, model(4'h0, 1'b1), e0);
        wait_cyc(e0 + 3);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        launch(4'h0, 1'b1, model(4'h0, 1'b1), e0);
        drain();

        for (int r = 0; r < 10; r++) begin
            fill_random();
            b = 4'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            launch(b, m, model(b, m), e0);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
